// File: rtl/exception_ctrl.sv
// MEM-stage exception detection and arbitration: forwards CP0 state, selects one
// exception by priority, drives the CP0 exception request and a timed pipeline flush.
module exception_ctrl #(
    parameter logic [31:0] HANDLER_PC   = 32'hBFC00380,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_pc_i,
    input  logic        mem_in_delayslot_i,
    input  logic [31:0] mem_addr_i,
    input  logic [8:0]  except_flags_i,
    input  logic [31:0] cp0_status_i,
    input  logic [31:0] cp0_cause_i,
    input  logic [31:0] cp0_epc_i,
    input  logic        wb_cp0_we_i,
    input  logic [4:0]  wb_cp0_waddr_i,
    input  logic [31:0] wb_cp0_data_i,
    output logic [31:0] excepttype_o,
    output logic [31:0] current_inst_addr_o,
    output logic        is_in_delayslot_o,
    output logic [31:0] bad_addr_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic        busy_o
);

    localparam int unsigned CNT_W = 4;
    localparam logic [4:0] CP0_REG_STATUS = 5'd12;
    localparam logic [4:0] CP0_REG_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_REG_EPC    = 5'd14;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    typedef enum logic {IDLE, FLUSH} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       excepttype_q, excepttype_d;
    logic [31:0]       inst_addr_q, inst_addr_d;
    logic              delayslot_q, delayslot_d;
    logic [31:0]       bad_addr_q, bad_addr_d;
    logic              flush_q, flush_d;
    logic [31:0]       new_pc_q, new_pc_d;
    logic              busy_q, busy_d;

    logic [31:0] status_c, cause_c, epc_c;
    logic        int_pending_c;
    logic [31:0] code_c;
    logic        code_bad_pc_c, code_bad_mem_c;

    // CP0 forwarding from WB; only the software interrupt bits of Cause are writable
    always_comb begin
        status_c = cp0_status_i;
        cause_c  = cp0_cause_i;
        epc_c    = cp0_epc_i;
        if (wb_cp0_we_i) begin
            if (wb_cp0_waddr_i == CP0_REG_STATUS) status_c = wb_cp0_data_i;
            if (wb_cp0_waddr_i == CP0_REG_CAUSE)  cause_c[9:8] = wb_cp0_data_i[9:8];
            if (wb_cp0_waddr_i == CP0_REG_EPC)    epc_c = wb_cp0_data_i;
        end
    end

    assign int_pending_c = ((cause_c[15:8] & status_c[15:8]) != 8'h00)
                           && status_c[0] && !status_c[1];

    // Priority encoder, first match wins
    always_comb begin
        code_c         = 32'h0;
        code_bad_pc_c  = 1'b0;
        code_bad_mem_c = 1'b0;
        if (int_pending_c)          code_c = 32'h1;
        else if (except_flags_i[0]) begin code_c = 32'h4; code_bad_pc_c = 1'b1; end
        else if (except_flags_i[3]) code_c = 32'ha;
        else if (except_flags_i[4]) code_c = 32'hc;
        else if (except_flags_i[1]) code_c = 32'h8;
        else if (except_flags_i[2]) code_c = 32'h9;
        else if (except_flags_i[5]) code_c = 32'hd;
        else if (except_flags_i[7]) begin code_c = 32'h4; code_bad_mem_c = 1'b1; end
        else if (except_flags_i[8]) begin code_c = 32'h5; code_bad_mem_c = 1'b1; end
        else if (except_flags_i[6]) code_c = 32'he;
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        excepttype_d = 32'h0;
        inst_addr_d  = inst_addr_q;
        delayslot_d  = delayslot_q;
        bad_addr_d   = bad_addr_q;
        new_pc_d     = new_pc_q;
        flush_d      = 1'b0;
        busy_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_valid_i && (code_c != 32'h0)) begin
                    state_d      = FLUSH;
                    cnt_d        = CNT_LOAD;
                    excepttype_d = code_c;
                    inst_addr_d  = mem_pc_i;
                    delayslot_d  = mem_in_delayslot_i;
                    new_pc_d     = (code_c == 32'he) ? epc_c : HANDLER_PC;
                    flush_d      = 1'b1;
                    busy_d       = 1'b1;
                    if (code_bad_pc_c)  bad_addr_d = mem_pc_i;
                    if (code_bad_mem_c) bad_addr_d = mem_addr_i;
                end
            end
            FLUSH: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                    flush_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            excepttype_q <= '0;
            inst_addr_q  <= '0;
            delayslot_q  <= 1'b0;
            bad_addr_q   <= '0;
            new_pc_q     <= '0;
            flush_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            excepttype_q <= excepttype_d;
            inst_addr_q  <= inst_addr_d;
            delayslot_q  <= delayslot_d;
            bad_addr_q   <= bad_addr_d;
            new_pc_q     <= new_pc_d;
            flush_q      <= flush_d;
            busy_q       <= busy_d;
        end
    end

    assign excepttype_o        = excepttype_q;
    assign current_inst_addr_o = inst_addr_q;
    assign is_in_delayslot_o   = delayslot_q;
    assign bad_addr_o          = bad_addr_q;
    assign flush_o             = flush_q;
    assign new_pc_o            = new_pc_q;
    assign busy_o              = busy_q;

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed-vector bench for exception_ctrl with hand-computed expectations.
module tb_exception_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid_i;
    logic [31:0] mem_pc_i;
    logic        mem_in_delayslot_i;
    logic [31:0] mem_addr_i;
    logic [8:0]  except_flags_i;
    logic [31:0] cp0_status_i;
    logic [31:0] cp0_cause_i;
    logic [31:0] cp0_epc_i;
    logic        wb_cp0_we_i;
    logic [4:0]  wb_cp0_waddr_i;
    logic [31:0] wb_cp0_data_i;
    logic [31:0] excepttype_o;
    logic [31:0] current_inst_addr_o;
    logic        is_in_delayslot_o;
    logic [31:0] bad_addr_o;
    logic        flush_o;
    logic [31:0] new_pc_o;
    logic        busy_o;

    int n_checks = 0;
    int n_pass   = 0;

    exception_ctrl dut (
        .clk                 (clk),
        .rst                 (rst),
        .mem_valid_i         (mem_valid_i),
        .mem_pc_i            (mem_pc_i),
        .mem_in_delayslot_i  (mem_in_delayslot_i),
        .mem_addr_i          (mem_addr_i),
        .except_flags_i      (except_flags_i),
        .cp0_status_i        (cp0_status_i),
        .cp0_cause_i         (cp0_cause_i),
        .cp0_epc_i           (cp0_epc_i),
        .wb_cp0_we_i         (wb_cp0_we_i),
        .wb_cp0_waddr_i      (wb_cp0_waddr_i),
        .wb_cp0_data_i       (wb_cp0_data_i),
        .excepttype_o        (excepttype_o),
        .current_inst_addr_o (current_inst_addr_o),
        .is_in_delayslot_o   (is_in_delayslot_o),
        .bad_addr_o          (bad_addr_o),
        .flush_o             (flush_o),
        .new_pc_o            (new_pc_o),
        .busy_o              (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Advance one cycle; inputs set after this are seen at the next edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        mem_valid_i        = 1'b0;
        mem_pc_i           = 32'h0;
        mem_in_delayslot_i = 1'b0;
        mem_addr_i         = 32'h0;
        except_flags_i     = 9'h0;
        cp0_status_i       = 32'h0;
        cp0_cause_i        = 32'h0;
        cp0_epc_i          = 32'h0;
        wb_cp0_we_i        = 1'b0;
        wb_cp0_waddr_i     = 5'd0;
        wb_cp0_data_i      = 32'h0;
    endtask

    task automatic present(input logic [8:0] flags, input logic [31:0] pc, input logic [31:0] addr,
                           input logic ds);
        mem_valid_i        = 1'b1;
        except_flags_i     = flags;
        mem_pc_i           = pc;
        mem_addr_i         = addr;
        mem_in_delayslot_i = ds;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;

        // Reset during FLUSH
        present(9'h002, 32'hBFC00100, 32'h0, 1'b0);
        step();
        check("rst_pre_flush", 32'(flush_o), 32'h1);
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        check("rst_flush", 32'(flush_o), 32'h0);
        check("rst_busy", 32'(busy_o), 32'h0);
        check("rst_exc", excepttype_o, 32'h0);
        check("rst_newpc", new_pc_o, 32'h0);
        check("rst_cia", current_inst_addr_o, 32'h0);
        check("rst_bad", bad_addr_o, 32'h0);

        // Syscall
        present(9'h002, 32'hBFC00100, 32'h0, 1'b0);
        step();
        check("sys_exc", excepttype_o, 32'h8);
        check("sys_cia", current_inst_addr_o, 32'hBFC00100);
        check("sys_newpc", new_pc_o, 32'hBFC00380);
        check("sys_ds", 32'(is_in_delayslot_o), 32'h0);
        check("sys_flush1", 32'(flush_o), 32'h1);
        check("sys_busy1", 32'(busy_o), 32'h1);
        clear_inputs();
        step();
        check("sys_exc_pulse", excepttype_o, 32'h0);
        check("sys_flush2", 32'(flush_o), 32'h1);
        step();
        check("sys_flush3", 32'(flush_o), 32'h0);
        check("sys_busy3", 32'(busy_o), 32'h0);
        check("sys_newpc_hold", new_pc_o, 32'hBFC00380);

        // Fetch misalign beats load misalign; bad addr is the PC
        present(9'h081, 32'h80000002, 32'h80001001, 1'b0);
        step();
        check("pri_exc", excepttype_o, 32'h4);
        check("pri_bad", bad_addr_o, 32'h80000002);
        clear_inputs();
        step();
        step();
        present(9'h100, 32'h80000004, 32'h80001003, 1'b0);
        step();
        check("sm_exc", excepttype_o, 32'h5);
        check("sm_bad", bad_addr_o, 32'h80001003);
        clear_inputs();
        step();
        step();

        // Interrupt: invalid instruction suppresses, WB status write masks
        cp0_status_i = 32'h00000401;
        cp0_cause_i  = 32'h00000400;
        step();
        check("int_novalid", excepttype_o, 32'h0);
        mem_valid_i    = 1'b1;
        wb_cp0_we_i    = 1'b1;
        wb_cp0_waddr_i = 5'd12;
        wb_cp0_data_i  = 32'h00000400;
        step();
        check("int_fwd_exc", excepttype_o, 32'h0);
        check("int_fwd_flush", 32'(flush_o), 32'h0);
        wb_cp0_we_i = 1'b0;
        step();
        check("int_exc", excepttype_o, 32'h1);
        check("int_newpc", new_pc_o, 32'hBFC00380);
        check("int_bad_hold", bad_addr_o, 32'h80001003);
        clear_inputs();
        step();
        step();

        // ERET with forwarded EPC
        present(9'h040, 32'h80000020, 32'h0, 1'b0);
        cp0_epc_i      = 32'h80000010;
        wb_cp0_we_i    = 1'b1;
        wb_cp0_waddr_i = 5'd14;
        wb_cp0_data_i  = 32'h80000040;
        step();
        check("eret_exc", excepttype_o, 32'he);
        check("eret_newpc", new_pc_o, 32'h80000040);
        clear_inputs();
        step();
        step();

        // Break during FLUSH is ignored, then taken in first IDLE cycle
        present(9'h002, 32'h80000100, 32'h0, 1'b1);
        step();
        check("mask_sys_exc", excepttype_o, 32'h8);
        check("mask_sys_ds", 32'(is_in_delayslot_o), 32'h1);
        present(9'h004, 32'h80000104, 32'h0, 1'b0);
        step();
        check("mask_exc1", excepttype_o, 32'h0);
        check("mask_cia1", current_inst_addr_o, 32'h80000100);
        step();
        check("mask_exc2", excepttype_o, 32'h0);
        check("mask_flush2", 32'(flush_o), 32'h0);
        check("mask_ds_hold", 32'(is_in_delayslot_o), 32'h1);
        step();
        check("brk_exc", excepttype_o, 32'h9);
        check("brk_cia", current_inst_addr_o, 32'h80000104);
        check("brk_ds", 32'(is_in_delayslot_o), 32'h0);
        check("brk_flush", 32'(flush_o), 32'h1);
        clear_inputs();
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
